// File: rtl/osc_period_meter_pkg.sv
// osc_period_meter_pkg
// Shared constants and types for the oscillator period meter.
//   OSC_DEPTH : sample width of the oscillator output
//   OSC_MID   : midscale of an unsigned OSC_DEPTH-bit sample
//   PER_W     : width of the period counter and reported period
//   per_t     : period type
//   sch_e     : Schmitt trigger state
//   meter_state_e : measurement FSM state
package osc_period_meter_pkg;

  localparam int OSC_DEPTH = 12;
  localparam int OSC_MID   = 2 ** (OSC_DEPTH - 1);
  localparam int PER_W     = 24;

  typedef logic [PER_W-1:0] per_t;

  typedef enum logic {
    SCH_LOW  = 1'b0,
    SCH_HIGH = 1'b1
  } sch_e;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } meter_state_e;

endpackage

// File: rtl/osc_period_meter_schmitt.sv
// osc_schmitt
// Registers the oscillator sample and runs a hysteresis comparator around
// midscale. Flags a rising crossing for exactly one cycle.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   v    : oscillator sample, unsigned
//   rise : high during the cycle in which the registered sample takes the
//          comparator from LOW to HIGH; the consumer acts on it at the next edge
module osc_schmitt
  import osc_period_meter_pkg::*;
#(
  parameter int DEPTH = OSC_DEPTH,
  parameter int HYST  = 2 ** (DEPTH - 4)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DEPTH-1:0] v,
  output logic             rise
);

  localparam logic [DEPTH-1:0] HI_TH = DEPTH'(2 ** (DEPTH - 1) + HYST);
  localparam logic [DEPTH-1:0] LO_TH = DEPTH'(2 ** (DEPTH - 1) - HYST);

  logic [DEPTH-1:0] v_q;
  sch_e             sch;

  // Sample register and hysteresis state; band between thresholds holds state.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      sch <= SCH_LOW;
    end else begin
      v_q <= v;
      case (sch)
        SCH_LOW:  if (v_q >= HI_TH) sch <= SCH_HIGH;
        SCH_HIGH: if (v_q <= LO_TH) sch <= SCH_LOW;
        default:  sch <= SCH_LOW;
      endcase
    end
  end

  // Decoded from the same condition that moves sch, so the meter sees the
  // crossing on the edge where sch flips.
  assign rise = (sch == SCH_LOW) && (v_q >= HI_TH);

endmodule

// File: rtl/osc_period_meter.sv
// osc_period_meter
// Times rising midscale crossings of the oscillator sample stream in clk
// cycles and reports the average over 2**AVG_LOG2 periods.
// Ports:
//   clk          : system clock, single domain
//   rst          : synchronous active-high reset
//   v            : oscillator sample, unsigned, midscale 2**(DEPTH-1)
//   period       : averaged period in clk cycles, held between strobes
//   period_valid : one-cycle strobe when period updates
//   locked       : a full window completed since reset or last timeout
//   timeout      : one-cycle strobe when no rise seen for TIMEOUT cycles
module osc_period_meter
  import osc_period_meter_pkg::*;
#(
  parameter int DEPTH    = OSC_DEPTH,
  parameter int CNT_W    = PER_W,
  parameter int HYST     = 2 ** (DEPTH - 4),
  parameter int AVG_LOG2 = 2,
  parameter int TIMEOUT  = 2 ** 23
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DEPTH-1:0] v,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             timeout
);

  localparam int ACC_W  = CNT_W + AVG_LOG2;
  localparam int NPER_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);
  // nper counts completed periods already folded into acc; the event that
  // arrives with this value closes the window.
  localparam logic [NPER_W-1:0] NPER_LAST = NPER_W'(2 ** AVG_LOG2 - 1);

  logic              rise;
  meter_state_e      state;
  logic [CNT_W-1:0]  cnt;
  logic [ACC_W-1:0]  acc;
  logic [NPER_W-1:0] nper;
  logic [ACC_W-1:0]  sum;

  osc_schmitt #(
    .DEPTH (DEPTH),
    .HYST  (HYST)
  ) u_schmitt (
    .clk  (clk),
    .rst  (rst),
    .v    (v),
    .rise (rise)
  );

  // Window total including the period that is closing right now.
  assign sum = acc + ACC_W'(cnt);

  // Measurement FSM: period counter, accumulator and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      acc          <= '0;
      nper         <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      timeout      <= 1'b0;
      case (state)
        ST_IDLE: begin
          acc  <= '0;
          nper <= '0;
          if (rise) begin
            state <= ST_MEASURE;
            cnt   <= CNT_W'(1);
          end else begin
            cnt <= '0;
          end
        end
        ST_MEASURE: begin
          // Timeout is checked first so a coincident rise is discarded.
          if (cnt == TIMEOUT_C) begin
            timeout <= 1'b1;
            locked  <= 1'b0;
            cnt     <= '0;
            acc     <= '0;
            nper    <= '0;
            state   <= ST_IDLE;
          end else if (rise) begin
            cnt <= CNT_W'(1);
            if (nper == NPER_LAST) begin
              period       <= CNT_W'(sum >> AVG_LOG2);
              period_valid <= 1'b1;
              locked       <= 1'b1;
              acc          <= '0;
              nper         <= '0;
            end else begin
              acc  <= sum;
              nper <= nper + NPER_W'(1);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
          acc   <= '0;
          nper  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_osc_period_meter.sv
// tb_osc_period_meter
// Drives square waves (clean, noisy, random, swept) into osc_period_meter and
// compares every cycle against a timestamp-based reference: the expected
// period is the edge distance across a window of rise events divided by the
// window length.
module tb_osc_period_meter;

  localparam int DEPTH = 12;
  localparam int CNT_W = 24;
  localparam int HYST  = 256;
  localparam int AVG_LOG2 = 2;
  localparam int NAVG  = 4;
  localparam int TMO   = 5000;
  localparam int MID   = 2048;
  localparam int HI    = MID + HYST;
  localparam int LO    = MID - HYST;
  localparam int VMAX  = 4095;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [DEPTH-1:0] v   = '0;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             locked;
  logic             timeout;

  always #5 clk = ~clk;

  osc_period_meter #(
    .DEPTH    (DEPTH),
    .CNT_W    (CNT_W),
    .HYST     (HYST),
    .AVG_LOG2 (AVG_LOG2),
    .TIMEOUT  (TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .v            (v),
    .period       (period),
    .period_valid (period_valid),
    .locked       (locked),
    .timeout      (timeout)
  );

  int vec  = 0;
  int miss = 0;

  // reference model state
  int  edge_n = 0;
  bit  meas = 1'b0, pend = 1'b0, sch_hi = 1'b0;
  int  win_start = 0, last_e = 0, nrise = 0, rise_cnt = 0;
  logic [CNT_W-1:0] m_period = '0;
  bit  m_valid = 1'b0, m_to = 1'b0, m_locked = 1'b0;

  // observations
  int    dev_cnt = 0;
  string dev_msg = "";
  bit    prev_locked = 1'b0;
  int    strobe_q[$];
  int    strobe_edge_q[$];
  int    strobe_rise_q[$];
  bit    strobe_prevlock_q[$];
  int    to_edge_q[$];

  // One clock: apply a sample, advance the reference, record DUT behaviour.
  task automatic step(input int val);
    v = DEPTH'(val);
    @(posedge clk);
    #1;
    edge_n++;
    m_valid = 1'b0;
    m_to    = 1'b0;
    if (rst) begin
      meas = 1'b0; pend = 1'b0; sch_hi = 1'b0;
      nrise = 0; rise_cnt = 0;
      m_period = '0; m_locked = 1'b0;
    end else begin
      if (meas && (edge_n - last_e) == TMO) begin
        m_to = 1'b1; m_locked = 1'b0; meas = 1'b0;
      end else if (pend) begin
        rise_cnt++;
        if (!meas) begin
          meas = 1'b1; win_start = edge_n; nrise = 0;
        end else begin
          nrise++;
          if (nrise == NAVG) begin
            m_period  = CNT_W'((edge_n - win_start) / NAVG);
            m_valid   = 1'b1;
            m_locked  = 1'b1;
            win_start = edge_n;
            nrise     = 0;
          end
        end
        last_e = edge_n;
      end
      pend = !sch_hi && (val >= HI);
      if (!sch_hi && val >= HI) sch_hi = 1'b1;
      else if (sch_hi && val <= LO) sch_hi = 1'b0;
    end
    if ({period_valid, timeout, locked} !== {m_valid, m_to, m_locked} || period !== m_period) begin
      if (dev_cnt == 0)
        dev_msg = $sformatf("edge %0d valid/timeout/locked=%b%b%b want %b%b%b period=%0d want %0d",
                            edge_n, period_valid, timeout, locked, m_valid, m_to, m_locked, period, m_period);
      dev_cnt++;
    end
    if (period_valid === 1'b1) begin
      strobe_q.push_back(int'(period));
      strobe_edge_q.push_back(edge_n);
      strobe_rise_q.push_back(rise_cnt);
      strobe_prevlock_q.push_back(prev_locked);
    end
    if (timeout === 1'b1) to_edge_q.push_back(edge_n);
    prev_locked = locked;
  endtask

  // One square-wave period; noisy versions wander inside the hysteresis band.
  task automatic drive_period(input int p, input bit noisy);
    for (int i = 0; i < p; i++) begin
      if (i < p / 2) step((i == 0 || !noisy) ? VMAX : int'($urandom_range(VMAX, LO + 1)));
      else           step((i == p / 2 || !noisy) ? 0 : int'($urandom_range(HI - 1, 0)));
    end
  endtask

  task automatic clear_obs();
    dev_cnt = 0;
    strobe_q.delete(); strobe_edge_q.delete(); strobe_rise_q.delete();
    strobe_prevlock_q.delete(); to_edge_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(0); step(0);
    rst = 1'b0;
    vec++; if (period !== 24'd0) begin miss++; $display("FAIL reset_period got %0d want 0", period); end
    vec++; if (period_valid !== 1'b0) begin miss++; $display("FAIL reset_valid got %b want 0", period_valid); end
    vec++; if (locked !== 1'b0) begin miss++; $display("FAIL reset_locked got %b want 0", locked); end
    vec++; if (timeout !== 1'b0) begin miss++; $display("FAIL reset_timeout got %b want 0", timeout); end
  endtask

  task automatic test_square();
    clear_obs();
    for (int k = 0; k < 12; k++) drive_period(1000, 1'b0);
    vec++; if (dev_cnt !== 0) begin miss++; $display("FAIL square_model %0d bad cycles, first: %s", dev_cnt, dev_msg); end
    vec++; if (strobe_q.size() !== 2) begin miss++; $display("FAIL square_strobes got %0d want 2", strobe_q.size()); end
    if (strobe_q.size() >= 2) begin
      vec++; if (strobe_q[0] !== 1000) begin miss++; $display("FAIL square_period got %0d want 1000", strobe_q[0]); end
      vec++; if (strobe_rise_q[0] !== 5) begin miss++; $display("FAIL square_first_rise got %0d want 5", strobe_rise_q[0]); end
      vec++; if (strobe_edge_q[1] - strobe_edge_q[0] !== 4000) begin miss++;
        $display("FAIL square_spacing got %0d want 4000", strobe_edge_q[1] - strobe_edge_q[0]); end
    end
    vec++; if (locked !== 1'b1) begin miss++; $display("FAIL square_locked got %b want 1", locked); end
  endtask

  task automatic test_avg();
    int pa[8] = '{1000, 1000, 1004, 1004, 1000, 1000, 1000, 1003};
    clear_obs();
    foreach (pa[i]) drive_period(pa[i], 1'b0);
    vec++; if (dev_cnt !== 0) begin miss++; $display("FAIL avg_model %0d bad cycles, first: %s", dev_cnt, dev_msg); end
    vec++; if (strobe_q.size() !== 2) begin miss++; $display("FAIL avg_strobes got %0d want 2", strobe_q.size()); end
    if (strobe_q.size() >= 2) begin
      vec++; if (strobe_q[0] !== 1000) begin miss++; $display("FAIL avg_prev_window got %0d want 1000", strobe_q[0]); end
      vec++; if (strobe_q[1] !== 1002) begin miss++; $display("FAIL avg_mean got %0d want 1002", strobe_q[1]); end
      vec++; if (strobe_edge_q[1] - strobe_edge_q[0] !== 4008) begin miss++;
        $display("FAIL avg_spacing got %0d want 4008", strobe_edge_q[1] - strobe_edge_q[0]); end
    end
  endtask

  task automatic test_noise();
    clear_obs();
    for (int k = 0; k < 5; k++) drive_period(1000, 1'b1);
    vec++; if (dev_cnt !== 0) begin miss++; $display("FAIL noise_model %0d bad cycles, first: %s", dev_cnt, dev_msg); end
    vec++; if (strobe_q.size() !== 2) begin miss++; $display("FAIL noise_strobes got %0d want 2", strobe_q.size()); end
    if (strobe_q.size() >= 2) begin
      vec++; if (strobe_q[0] !== 1000) begin miss++; $display("FAIL trunc_period got %0d want 1000", strobe_q[0]); end
      vec++; if (strobe_q[1] !== 1000) begin miss++; $display("FAIL noise_period got %0d want 1000", strobe_q[1]); end
    end
  endtask

  task automatic test_random();
    clear_obs();
    for (int k = 0; k < 8; k++) drive_period(int'($urandom_range(1500, 300)), bit'($urandom_range(1, 0)));
    vec++; if (dev_cnt !== 0) begin miss++; $display("FAIL random_model %0d bad cycles, first: %s", dev_cnt, dev_msg); end
  endtask

  task automatic test_timeout();
    logic [CNT_W-1:0] held;
    int rise_edge;
    clear_obs();
    held = m_period;
    rise_edge = last_e;
    for (int i = 0; i < TMO + 10; i++) step(MID);
    vec++; if (dev_cnt !== 0) begin miss++; $display("FAIL timeout_model %0d bad cycles, first: %s", dev_cnt, dev_msg); end
    vec++; if (to_edge_q.size() !== 1) begin miss++; $display("FAIL timeout_pulses got %0d want 1", to_edge_q.size()); end
    if (to_edge_q.size() >= 1) begin
      vec++; if (to_edge_q[0] - rise_edge !== TMO) begin miss++;
        $display("FAIL timeout_delay got %0d want %0d", to_edge_q[0] - rise_edge, TMO); end
    end
    vec++; if (locked !== 1'b0) begin miss++; $display("FAIL timeout_locked got %b want 0", locked); end
    vec++; if (period !== held) begin miss++; $display("FAIL timeout_period_hold got %0d want %0d", period, held); end
  endtask

  task automatic test_sweep();
    clear_obs();
    for (int key = 0; key < 5; key++)
      for (int k = 0; k < 4; k++) drive_period(1200 - 60 * key, 1'b0);
    step(VMAX); step(VMAX);
    vec++; if (dev_cnt !== 0) begin miss++; $display("FAIL sweep_model %0d bad cycles, first: %s", dev_cnt, dev_msg); end
    vec++; if (strobe_q.size() !== 5) begin miss++; $display("FAIL sweep_strobes got %0d want 5", strobe_q.size()); end
    if (strobe_q.size() >= 1) begin
      vec++; if (strobe_prevlock_q[0] !== 1'b0) begin miss++; $display("FAIL sweep_lock_rise prev locked %b want 0", strobe_prevlock_q[0]); end
      vec++; if (strobe_q[0] !== 1200) begin miss++; $display("FAIL sweep_first got %0d want 1200", strobe_q[0]); end
    end
    for (int i = 1; i < strobe_q.size(); i++) begin
      vec++; if (strobe_q[i] > strobe_q[i-1]) begin miss++;
        $display("FAIL sweep_monotonic strobe %0d got %0d after %0d", i, strobe_q[i], strobe_q[i-1]); end
    end
  endtask

  task automatic test_reset_mid();
    clear_obs();
    drive_period(1000, 1'b0); drive_period(1000, 1'b0);
    for (int i = 0; i < 100; i++) step(VMAX);
    rst = 1'b1;
    step(0);
    rst = 1'b0;
    vec++; if ({period_valid, locked, timeout} !== 3'b000 || period !== 24'd0) begin miss++;
      $display("FAIL midreset_outputs got valid/locked/timeout=%b%b%b period=%0d want 000 0",
               period_valid, locked, timeout, period); end
    clear_obs();
    for (int k = 0; k < 4; k++) drive_period(1000, 1'b0);
    vec++; if (strobe_q.size() !== 0) begin miss++; $display("FAIL midreset_early got %0d strobes want 0", strobe_q.size()); end
    step(VMAX); step(VMAX);
    vec++; if (strobe_q.size() !== 1) begin miss++; $display("FAIL midreset_strobe got %0d want 1", strobe_q.size()); end
    if (strobe_q.size() >= 1) begin
      vec++; if (strobe_q[0] !== 1000) begin miss++; $display("FAIL midreset_period got %0d want 1000", strobe_q[0]); end
      vec++; if (strobe_rise_q[0] !== 5) begin miss++; $display("FAIL midreset_rise got %0d want 5", strobe_rise_q[0]); end
    end
    vec++; if (dev_cnt !== 0) begin miss++; $display("FAIL midreset_model %0d bad cycles, first: %s", dev_cnt, dev_msg); end
  endtask

  initial begin
    test_reset();
    test_square();
    test_avg();
    test_noise();
    test_random();
    test_timeout();
    test_sweep();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
